// File: rtl/edge_capture_pkg.sv
// Shared definitions for the edge capture block: default parameters and the
// packed record layout {edges, levels, timestamp}.
package edge_capture_pkg;

   localparam int DATAWIDTH_DEF = 1;
   localparam int TSWIDTH_DEF   = 16;
   localparam int DEPTHLOG2_DEF = 3;
   localparam int DROPWIDTH_DEF = 8;

   // Record layout, LSB first: timestamp, then levels, then edges.
   function automatic int rec_w(input int dw, input int tsw);
      return 2 * dw + tsw;
   endfunction

   function automatic int ts_lsb(input int dw, input int tsw);
      return 0;
   endfunction

   function automatic int lvl_lsb(input int dw, input int tsw);
      return tsw;
   endfunction

   function automatic int edg_lsb(input int dw, input int tsw);
      return tsw + dw;
   endfunction

endpackage

// File: rtl/edge_capture_if.sv
// Valid/ready record stream carrying captured edge events.
interface edge_capture_if #(
   parameter int DATAWIDTH = 1,
   parameter int TSWIDTH   = 16
);
   logic                 ev_valid;
   logic                 ev_ready;
   logic [DATAWIDTH-1:0] ev_edges;
   logic [DATAWIDTH-1:0] ev_levels;
   logic [TSWIDTH-1:0]   ev_ts;

   modport master (
      output ev_valid,
      output ev_edges,
      output ev_levels,
      output ev_ts,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_edges,
      input  ev_levels,
      input  ev_ts,
      output ev_ready
   );
endinterface

// File: rtl/edge_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO; read data comes straight from the
// storage registers so the head record is visible the cycle after it is written.
module sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTHLOG2 = 3
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int DEPTH = 1 << DEPTHLOG2;

   logic [DEPTHLOG2:0] wptr_q, wptr_d;
   logic [DEPTHLOG2:0] rptr_q, rptr_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic               wr_en;
   logic               rd_en;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[DEPTHLOG2] != rptr_q[DEPTHLOG2]) &&
                    (wptr_q[DEPTHLOG2-1:0] == rptr_q[DEPTHLOG2-1:0]);

   // When full, a write is only legal because the head slot is leaving this cycle.
   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   assign rdata_o = mem_q[rptr_q[DEPTHLOG2-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_en) wptr_d = wptr_q + (DEPTHLOG2+1)'(1);
      if (rd_en) rptr_d = rptr_q + (DEPTHLOG2+1)'(1);
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (wr_en) mem_q[wptr_q[DEPTHLOG2-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/edge_capture.sv
// Timestamps cycles carrying edge pulses and queues {edges, levels, ts} records
// for a valid/ready consumer, with sticky overflow and a saturating drop count.
module edge_capture
   import edge_capture_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int TSWIDTH   = TSWIDTH_DEF,
   parameter int DEPTHLOG2 = DEPTHLOG2_DEF,
   parameter int DROPWIDTH = DROPWIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic [DATAWIDTH-1:0] edge_i,
   input  logic [DATAWIDTH-1:0] level_i,
   input  logic                 clr_ovf,
   output logic                 ovf,
   output logic [DROPWIDTH-1:0] drops,
   edge_capture_if.master       ev
);
   localparam int REC_W   = rec_w(DATAWIDTH, TSWIDTH);
   localparam int TS_LSB  = ts_lsb(DATAWIDTH, TSWIDTH);
   localparam int LVL_LSB = lvl_lsb(DATAWIDTH, TSWIDTH);
   localparam int EDG_LSB = edg_lsb(DATAWIDTH, TSWIDTH);

   logic [TSWIDTH-1:0]   ts_q, ts_d;
   logic                 ovf_q, ovf_d;
   logic [DROPWIDTH-1:0] drops_q, drops_d;

   logic             event_v;
   logic             pop;
   logic             push;
   logic             drop;
   logic             full;
   logic             empty;
   logic [REC_W-1:0] wrec;
   logic [REC_W-1:0] rrec;

   assign event_v = |edge_i;
   assign pop     = !empty && ev.ev_ready;
   assign push    = event_v && (!full || pop);
   assign drop    = event_v && full && !pop;

   assign wrec = {edge_i, level_i, ts_q};

   sync_fifo #(
      .WIDTH     (REC_W),
      .DEPTHLOG2 (DEPTHLOG2)
   ) u_fifo (
      .clk     (clk),
      .reset_l (reset_l),
      .push_i  (push),
      .wdata_i (wrec),
      .pop_i   (pop),
      .rdata_o (rrec),
      .full_o  (full),
      .empty_o (empty)
   );

   assign ev.ev_valid  = !empty;
   assign ev.ev_edges  = rrec[EDG_LSB +: DATAWIDTH];
   assign ev.ev_levels = rrec[LVL_LSB +: DATAWIDTH];
   assign ev.ev_ts     = rrec[TS_LSB +: TSWIDTH];

   assign ovf   = ovf_q;
   assign drops = drops_q;

   // A drop in the same cycle as a clear restarts the count at one.
   always_comb begin
      ts_d    = ts_q + TSWIDTH'(1);
      ovf_d   = ovf_q;
      drops_d = drops_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (clr_ovf)       drops_d = DROPWIDTH'(1);
         else if (!(&drops_q)) drops_d = drops_q + DROPWIDTH'(1);
      end else if (clr_ovf) begin
         ovf_d   = 1'b0;
         drops_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         ts_q    <= '0;
         ovf_q   <= 1'b0;
         drops_q <= '0;
      end else begin
         ts_q    <= ts_d;
         ovf_q   <= ovf_d;
         drops_q <= drops_d;
      end
   end

endmodule
